// File: rtl/ibex_pkg.sv
// Shared types for the FPGA register-file write buffer.
package ibex_pkg;

  localparam int unsigned RfDataWidth = 32;

  typedef struct packed {
    logic [4:0]             waddr;
    logic [RfDataWidth-1:0] wdata;
  } rf_wr_t;

  typedef enum logic {
    RF_WB_IDLE,
    RF_WB_LOAD_PEND
  } rf_wb_state_e;

endpackage

// File: rtl/ibex_rf_write_buffer_if.sv
// Write-source, register-file and ID-read signals of the write buffer, grouped with modports.
interface ibex_rf_write_buffer_if #(
  parameter int unsigned DataWidth = 32
);

  logic                 ex_we_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ex_ready_o;

  logic                 lsu_req_i;
  logic [4:0]           lsu_rd_i;
  logic                 lsu_rvalid_i;
  logic [DataWidth-1:0] lsu_rdata_i;
  logic                 lsu_err_i;

  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;

  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 hazard_a_o;
  logic                 hazard_b_o;
  logic                 fwd_a_valid_o;
  logic                 fwd_b_valid_o;
  logic [DataWidth-1:0] fwd_a_data_o;
  logic [DataWidth-1:0] fwd_b_data_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_req_i, lsu_rd_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  raddr_a_i, raddr_b_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output hazard_a_o, hazard_b_o, fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_req_i, lsu_rd_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output raddr_a_i, raddr_b_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  hazard_a_o, hazard_b_o, fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o
  );

endinterface

// File: rtl/ibex_rf_wr_fifo.sv
// Small EX-write FIFO kept as a shift register: entry 0 is the oldest, so the parent can
// scan entries in age order for hazard and forwarding compares.
module ibex_rf_wr_fifo
  import ibex_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  rf_wr_t          wdata,
  input  logic            pop,
  output logic [CntW-1:0] count,
  output rf_wr_t          entries [Depth],
  output logic [Depth-1:0] valid
);

  rf_wr_t          mem_q [Depth];
  rf_wr_t          mem_d [Depth];
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] wr_idx;

  always_comb begin
    mem_d   = mem_q;
    wr_idx  = pop ? count_q - CntW'(1) : count_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (pop) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    // Tail slot is computed after the shift so push and pop may coincide.
    for (int i = 0; i < int'(Depth); i++) begin
      if (push && (CntW'(i) == wr_idx)) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      valid[i] = CntW'(i) < count_q;
    end
  end

  assign count   = count_q;
  assign entries = mem_q;

  push_not_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_q == CntW'(Depth))));
  pop_not_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && (count_q == '0)));

endmodule

// File: rtl/ibex_rf_write_buffer.sv
// Merges EX results and load returns onto the single register-file write port and reports
// read-after-write hazards. Optional operand bypass: define IBEX_RF_WB_BYPASS_EN.
module ibex_rf_write_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = RfDataWidth,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned Depth     = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  ibex_rf_write_buffer_if.slave bus
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  rf_wb_state_e         state_q, state_d;
  logic [4:0]           ld_rd_q, ld_rd_d;

  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

  logic [CntW-1:0]      count;
  rf_wr_t               entries [Depth];
  logic [Depth-1:0]     ent_valid;
  logic                 push, pop;
  rf_wr_t               fifo_wdata;

  logic                 fifo_empty, ex_ready, ex_take, ld_resp, ld_wr;

  ibex_rf_wr_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .count   (count),
    .entries (entries),
    .valid   (ent_valid)
  );

  assign fifo_empty = (count == '0);
  assign ld_resp    = (state_q == RF_WB_LOAD_PEND) && bus.lsu_rvalid_i;
  assign ld_wr      = ld_resp && !bus.lsu_err_i;
  // Blocks WAW against the outstanding load regardless of whether EX is asking this cycle.
  assign ex_ready   = (count < CntW'(Depth)) &&
                      !((state_q == RF_WB_LOAD_PEND) && (bus.ex_waddr_i == ld_rd_q));
  assign ex_take    = bus.ex_we_i && (bus.ex_waddr_i != 5'd0) && ex_ready;

  // Load FSM.
  always_comb begin
    state_d = state_q;
    ld_rd_d = ld_rd_q;
    unique case (state_q)
      RF_WB_IDLE: begin
        if (bus.lsu_req_i && (bus.lsu_rd_i != 5'd0)) begin
          state_d = RF_WB_LOAD_PEND;
          ld_rd_d = bus.lsu_rd_i;
        end
      end
      RF_WB_LOAD_PEND: begin
        if (bus.lsu_rvalid_i) begin
          state_d = RF_WB_IDLE;
        end
      end
      default: state_d = RF_WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_WB_IDLE;
      ld_rd_q <= 5'd0;
    end else begin
      state_q <= state_d;
      ld_rd_q <= ld_rd_d;
    end
  end

  // Write-port arbitration: load response, then buffer head, then direct EX.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    push       = 1'b0;
    pop        = 1'b0;
    fifo_wdata = '{waddr: bus.ex_waddr_i, wdata: bus.ex_wdata_i};
    if (ld_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ld_rd_q;
      rf_wdata_d = bus.lsu_rdata_i;
      push       = ex_take;
    end else if (!fifo_empty) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = entries[0].waddr;
      rf_wdata_d = entries[0].wdata;
      pop        = 1'b1;
      push       = ex_take;
    end else if (ex_take) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.ex_waddr_i;
      rf_wdata_d = bus.ex_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Hazard lookup, scanned oldest to youngest so the last hit is the youngest write.
  logic [4:0]           raddr     [2];
  logic                 ld_match  [2];
  logic                 hit       [2];
  logic                 hazard    [2];
  logic                 fwd_valid [2];
  logic [DataWidth-1:0] fwd_data  [2];
`ifdef IBEX_RF_WB_BYPASS_EN
  logic [DataWidth-1:0] hit_data  [2];
`endif

  assign raddr[0] = bus.raddr_a_i;
  assign raddr[1] = bus.raddr_b_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      ld_match[p] = 1'b0;
      hit[p]      = 1'b0;
`ifdef IBEX_RF_WB_BYPASS_EN
      hit_data[p] = '0;
`endif
      if (raddr[p] != 5'd0) begin
        ld_match[p] = (state_q == RF_WB_LOAD_PEND) && (ld_rd_q == raddr[p]);
        if (rf_we_q && (rf_waddr_q == raddr[p])) begin
          hit[p] = 1'b1;
`ifdef IBEX_RF_WB_BYPASS_EN
          hit_data[p] = rf_wdata_q;
`endif
        end
        for (int i = 0; i < int'(Depth); i++) begin
          if (ent_valid[i] && (entries[i].waddr == raddr[p])) begin
            hit[p] = 1'b1;
`ifdef IBEX_RF_WB_BYPASS_EN
            hit_data[p] = entries[i].wdata;
`endif
          end
        end
      end
`ifdef IBEX_RF_WB_BYPASS_EN
      // A pending load is younger than anything buffered and its data is not here yet.
      hazard[p]    = ld_match[p];
      fwd_valid[p] = hit[p] && !ld_match[p];
      fwd_data[p]  = fwd_valid[p] ? hit_data[p] : '0;
`else
      hazard[p]    = ld_match[p] || hit[p];
      fwd_valid[p] = 1'b0;
      fwd_data[p]  = '0;
`endif
    end
  end

  assign bus.ex_ready_o    = ex_ready;
  assign bus.rf_we_o       = rf_we_q;
  assign bus.rf_waddr_o    = rf_waddr_q;
  assign bus.rf_wdata_o    = rf_wdata_q;
  assign bus.hazard_a_o    = hazard[0];
  assign bus.hazard_b_o    = hazard[1];
  assign bus.fwd_a_valid_o = fwd_valid[0];
  assign bus.fwd_b_valid_o = fwd_valid[1];
  assign bus.fwd_a_data_o  = fwd_data[0];
  assign bus.fwd_b_data_o  = fwd_data[1];

  // Only one load may be outstanding; a second request is dropped by the FSM.
  load_req_while_pending_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((state_q == RF_WB_LOAD_PEND) && bus.lsu_req_i));

  if (RV32E) begin : gen_rv32e_chk
    rv32e_addr_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.ex_we_i && bus.ex_waddr_i[4]) && !(bus.lsu_req_i && bus.lsu_rd_i[4]) &&
      !bus.raddr_a_i[4] && !bus.raddr_b_i[4]);
  end

endmodule

// File: doc/ibex_rf_write_buffer.md
# ibex_rf_write_buffer

Write-side front end for the FPGA register file. It merges two write sources into the register file's single write port: ALU/CSR results from EX, and late load data from the LSU. It buffers EX writes that collide with a load return. It also reports read-after-write hazards on both read addresses so ID can stall or forward.

## Interface
- `DataWidth`, 32: register data width.
- `RV32E`, 0: 1 restricts to x0..x15; bit 4 of every address must be 0.
- `Depth`, 2: EX write buffer entries, 1..4.
- `clk_i` in 1: clock. One clock; all state on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `ex_we_i` in 1, `ex_waddr_i` in 5, `ex_wdata_i` in DataWidth: EX write request.
- `ex_ready_o` out 1: EX write accepted this cycle when `ex_we_i && ex_ready_o`.
- `lsu_req_i` in 1, `lsu_rd_i` in 5: load issued; reserves destination `lsu_rd_i`.
- `lsu_rvalid_i` in 1, `lsu_rdata_i` in DataWidth, `lsu_err_i` in 1: load response.
- `rf_we_o` out 1, `rf_waddr_o` out 5, `rf_wdata_o` out DataWidth: to register file write port.
- `raddr_a_i`, `raddr_b_i` in 5: ID read addresses.
- `hazard_a_o`, `hazard_b_o` out 1: read address has a write pending.
- `fwd_a_valid_o`, `fwd_b_valid_o` out 1 and `fwd_a_data_o`, `fwd_b_data_o` out DataWidth: forwarded operand.

## Operation
- Writes to x0 are dropped at input. They never enqueue, never reserve, and never raise a hazard.
- FSM `IDLE` -> `LOAD_PEND` on `lsu_req_i` with `lsu_rd_i != 0`, latching `ld_rd`.
- FSM `LOAD_PEND` -> `IDLE` on `lsu_rvalid_i`.
- A load to x0 stays in `IDLE`. Its response is still consumed.
- `lsu_req_i` in `LOAD_PEND` is illegal: it is ignored and flagged by an assertion.
- `lsu_rvalid_i` in `IDLE` is ignored.
- On `lsu_err_i && lsu_rvalid_i`: no write; the reservation is released.
- Port arbitration each cycle, fixed priority:
  1. Load response (no error).
  2. Buffer head.
  3. Direct EX write, only when the buffer is empty.
- An accepted EX write that loses arbitration, or arrives while the buffer is non-empty, enqueues at the tail. FIFO order is preserved.
- `ex_ready_o = (count < Depth) && !(state == LOAD_PEND && ex_waddr_i == ld_rd)`. This blocks WAW against an outstanding load and is independent of `ex_we_i` timing.
- `hazard_x_o` is 1 when `raddr_x != 0` and it matches any of:
  - `ld_rd` in `LOAD_PEND`;
  - any valid buffer entry;
  - the output register while `rf_we_o == 1`.
- When several pending entries match, the youngest wins: buffer tail -> older entries -> output register.

## Timing
- Selected write appears on `rf_*_o` one cycle after acceptance (registered output).
- The register file holds the value one edge later.
- A direct EX write therefore takes 2 edges from `ex_we_i` to register file contents.
- The buffer drains one entry per cycle when no load response competes.
- A simultaneous enqueue and dequeue keeps `count` unchanged.
- Reset values:
  - `rf_we_o` = 0, `rf_waddr_o` = 0, `rf_wdata_o` = 0;
  - `ex_ready_o` = 1;
  - all hazard and fwd outputs = 0;
  - state `IDLE`, `count` = 0.
- Asserting reset mid-operation discards buffered writes and the reservation with no register file write.
- Hazard and fwd outputs are combinational from the current state and read addresses. There is no same-cycle path from `ex_*` inputs.

## Configuration
- Macro: `IBEX_RF_WB_BYPASS_EN`.
- Defined: a match on a buffer entry or the output register drives `fwd_x_valid_o = 1` with the youngest data, and `hazard_x_o = 0` for that port. A match on `ld_rd` still raises the hazard, since the data does not exist yet.
- Undefined: `fwd_*_o` are tied to 0 and every match raises a hazard.

## Structure
- Shared package `ibex_pkg` holds:
  - `rf_wr_t` struct `{waddr[4:0], wdata[DataWidth-1:0]}`;
  - enum `rf_wb_state_e {RF_WB_IDLE, RF_WB_LOAD_PEND}`.
- One sub-module, `ibex_rf_wr_fifo`:
  - holds `Depth` entries of `rf_wr_t` with a count;
  - exposes every entry's valid and address to the parent for hazard compare.

## Test plan
- EX writes x5=0x11 with no load -> `rf_we_o` = 1, `rf_waddr_o` = 5, `rf_wdata_o` = 0x11 next cycle; `hazard_a_o` = 1 for `raddr_a_i` = 5 during that cycle.
- Load to x7 issued, EX writes x3=0xAA the same cycle the load returns 0x55 -> x7=0x55 is written first, x3=0xAA the following cycle.
- Load to x9 outstanding, EX attempts x9 -> `ex_ready_o` = 0 until the response; `hazard_b_o` = 1 for `raddr_b_i` = 9.
- Load returns fill the buffer to `Depth` -> `ex_ready_o` = 0, then recovers after one drain cycle; no write is lost or reordered.
- Load to x4 returns with `lsu_err_i` = 1 -> no register file write, state returns to `IDLE`; EX write x0=0x1 -> `rf_we_o` stays 0.
- With `IBEX_RF_WB_BYPASS_EN`: x6=0x1 then x6=0x2 buffered -> `fwd_a_data_o` = 0x2, `hazard_a_o` = 0; async reset mid-drain -> all outputs 0, buffer empty.
